// File: rtl/tmr_voter_monitor.sv
// tmr_voter_monitor: registered TMR array voter with per-way fault tracking and duplex fallback
module tmr_voter_monitor #(
    parameter int W      = 32,
    parameter int U      = 4,
    parameter int CNT_W  = 8,
    parameter int THRESH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         valid_i,
    input  logic [W-1:0] in0 [0:U-1],
    input  logic [W-1:0] in1 [0:U-1],
    input  logic [W-1:0] in2 [0:U-1],
    output logic         valid_o,
    output logic [W-1:0] out [0:U-1],
    output logic         error1_o,
    output logic         error2_o,
    output logic [2:0]   way_faulty_o,
    output logic [1:0]   state_o
);
    typedef enum logic [1:0] {NORMAL = 2'd0, DEGRADED = 2'd1, FAILED = 2'd2} state_t;
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] TH  = CNT_W'(THRESH);
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt [0:2];
    logic [CNT_W-1:0] cnt_n [0:2];
    logic [CNT_W-1:0] dcnt, dcnt_n;
    logic [2:0]       faulty_n;
    logic [1:0]       sel, way_a, way_b, sole, minor;
    logic             eq01, eq02, eq12, eq_ab, all_diff, e1_n, e2_n;
    logic [W-1:0]     vote [0:U-1];

    assign state_o = state;
    // surviving pair in DEGRADED (a < b) and sole survivor in FAILED
    assign way_a   = way_faulty_o[0] ? 2'd1 : 2'd0;
    assign way_b   = way_faulty_o[2] ? 2'd1 : 2'd2;
    assign sole    = !way_faulty_o[0] ? 2'd0 : !way_faulty_o[1] ? 2'd1 : 2'd2;
    assign eq_ab   = way_faulty_o[0] ? eq12 : way_faulty_o[1] ? eq02 : eq01;
    assign all_diff = !eq01 && !eq02 && !eq12;

    // whole-array pairwise equality
    always_comb begin
        eq01 = 1'b1;
        eq02 = 1'b1;
        eq12 = 1'b1;
        for (int u = 0; u < U; u++) begin
            eq01 = eq01 && (in0[u] == in1[u]);
            eq02 = eq02 && (in0[u] == in2[u]);
            eq12 = eq12 && (in1[u] == in2[u]);
        end
    end

    // vote selection, error flags and next counter/flag/state values
    always_comb begin
        sel      = 2'd0;
        e1_n     = 1'b0;
        e2_n     = 1'b0;
        minor    = 2'd3;
        state_n  = state;
        faulty_n = way_faulty_o;
        dcnt_n   = dcnt;
        cnt_n    = cnt;
        if (state == NORMAL) begin
            minor = (eq01 && eq02) ? 2'd3 : eq01 ? 2'd2 : eq02 ? 2'd1 : eq12 ? 2'd0 : 2'd3;
            sel   = (minor == 2'd0) ? 2'd1 : 2'd0;
            e1_n  = !(eq01 && eq02);
            e2_n  = all_diff;
            for (int k = 0; k < 3; k++) begin
                if (!all_diff)
                    cnt_n[k] = (minor == 2'(k)) ? ((cnt[k] == MAX) ? MAX : cnt[k] + 1'b1) : '0;
                if (minor == 2'(k) && cnt_n[k] == TH) begin
                    faulty_n[k] = 1'b1;
                    state_n     = DEGRADED;
                end
            end
        end else if (state == DEGRADED) begin
            sel    = way_a;
            e2_n   = !eq_ab;
            dcnt_n = eq_ab ? '0 : (dcnt == MAX) ? MAX : dcnt + 1'b1;
            if (dcnt_n == TH) begin
                faulty_n[way_b] = 1'b1;
                state_n         = FAILED;
            end
        end else begin
            sel  = sole;
            e2_n = 1'b1;
        end
        for (int u = 0; u < U; u++)
            vote[u] = (sel == 2'd0) ? in0[u] : (sel == 2'd1) ? in1[u] : in2[u];
    end

    // output registers and health state; clear discards the beat's health update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o      <= 1'b0;
            error1_o     <= 1'b0;
            error2_o     <= 1'b0;
            way_faulty_o <= '0;
            state        <= NORMAL;
            dcnt         <= '0;
            for (int u = 0; u < U; u++) out[u] <= '0;
            for (int k = 0; k < 3; k++) cnt[k] <= '0;
        end else begin
            valid_o  <= valid_i;
            error1_o <= valid_i && e1_n;
            error2_o <= valid_i && e2_n;
            if (valid_i) out <= vote;
            if (clear_i) begin
                way_faulty_o <= '0;
                state        <= NORMAL;
                dcnt         <= '0;
                for (int k = 0; k < 3; k++) cnt[k] <= '0;
            end else if (valid_i) begin
                way_faulty_o <= faulty_n;
                state        <= state_n;
                dcnt         <= dcnt_n;
                cnt          <= cnt_n;
            end
        end
    end
endmodule
